reg_file: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file for the single-cycle datapath.
- Directly upstream of the ALU: read port 1 drives ALU srca; read port 2 drives the srcb mux and store data.
- One synchronous write port is fed from the writeback mux (ALU result or memory data).
- Register $0 is hardwired to zero. $sp and $gp have parameterised reset values.

---
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32 x WIDTH MIPS register file: two combinational read ports, one synchronous write port.
// $0 reads as zero; $gp/$sp reset to GP_INIT/SP_INIT; optional same-cycle write-to-read bypass.
module reg_file #(
  parameter int unsigned           WIDTH   = 32,
  parameter logic [WIDTH-1:0]      SP_INIT = 32'h0000_7FFC,
  parameter logic [WIDTH-1:0]      GP_INIT = 32'h0000_1800,
  parameter bit                    BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  input  logic             we3,
  input  logic [4:0]       wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  localparam logic [4:0] GP_IDX = 5'd28;
  localparam logic [4:0] SP_IDX = 5'd29;

  logic [WIDTH-1:0] regs_q [1:31];
  logic [WIDTH-1:0] regs_d [1:31];
  logic             wr_en;
  logic             byp_en;

  function automatic logic [WIDTH-1:0] rst_val(input logic [4:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    if (idx == GP_IDX) v = GP_INIT;
    if (idx == SP_IDX) v = SP_INIT;
    return v;
  endfunction

  assign wr_en  = we3 && (wa3 != 5'd0);
  // Bypass is masked during reset so a write that will be dropped is never observed.
  assign byp_en = BYPASS && wr_en && rst_n;

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wa3] = wd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= rst_val(5'(i));
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != 5'd0) begin
      rd1 = regs_q[ra1];
      if (byp_en && (ra1 == wa3)) rd1 = wd3;
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != 5'd0) begin
      rd2 = regs_q[ra2];
      if (byp_en && (ra2 == wa3)) rd2 = wd3;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one bypassing and one non-bypassing instance share stimulus.
module tb_reg_file;

  localparam logic [31:0] SP_V = 32'h0000_7FFC;
  localparam logic [31:0] GP_V = 32'h0000_1800;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa3 = '0;
  logic        we3 = 1'b0;
  logic [31:0] wd3 = '0;
  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;

  reg_file #(.WIDTH(32), .SP_INIT(SP_V), .GP_INIT(GP_V), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .rd1(b_rd1), .rd2(b_rd2));

  reg_file #(.WIDTH(32), .SP_INIT(SP_V), .GP_INIT(GP_V), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .rd1(n_rd1), .rd2(n_rd2));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    string       name;
    int          port;   // 0: byp rd1, 1: byp rd2, 2: nob rd1, 3: nob rd2
    logic [31:0] exp;
  } chk_t;

  chk_t queue_q[$];
  event smp_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_v(input string name, input int port, input logic [31:0] v);
    chk_t c;
    c.name = name; c.port = port; c.exp = v;
    queue_q.push_back(c);
  endtask

  // Same expected value on one read port of both instances.
  task automatic expect_both(input string name, input int rd, input logic [31:0] v);
    expect_v(name, rd, v);
    expect_v(name, rd + 2, v);
  endtask

  task automatic sample();
    #1;
    -> smp_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always begin
    @(smp_ev);
    while (queue_q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = queue_q.pop_front();
      case (c.port)
        0: act = b_rd1;
        1: act = b_rd2;
        2: act = n_rd1;
        default: act = n_rd2;
      endcase
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s port%0d got %h expected %h", c.name, c.port, act, c.exp);
      end
    end
  end

  logic [4:0] perm [32];

  initial begin
    // Reset asserted with the clock stopped must take effect immediately.
    #3 rst_n = 1'b0;
    ra1 = 5'd28; ra2 = 5'd29;
    #1;
    expect_both("rst_async_gp", 0, GP_V);
    expect_both("rst_async_sp", 1, SP_V);
    sample();

    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      expect_both("rst_sweep1", 0, (i == 28) ? GP_V : (i == 29) ? SP_V : 32'h0);
      expect_both("rst_sweep2", 1, ((31 - i) == 28) ? GP_V : ((31 - i) == 29) ? SP_V : 32'h0);
      sample();
    end

    // Writes presented while reset is held are lost.
    clk_en = 1'b1;
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hCAFE_0005;
    tick();
    tick();
    we3 = 1'b0;
    rst_n = 1'b1;
    ra1 = 5'd5;
    expect_both("wr_in_reset", 0, 32'h0);
    sample();

    // First write after release lands on the first rising edge.
    we3 = 1'b1; wa3 = 5'd8; wd3 = 32'hDEAD_BEEF; ra1 = 5'd8; ra2 = 5'd8;
    expect_v("basic_pre_byp", 0, 32'hDEAD_BEEF);
    expect_v("basic_pre_nob", 2, 32'h0);
    sample();
    tick();
    we3 = 1'b0; wd3 = 32'h0000_1234;
    expect_both("basic_rd1", 0, 32'hDEAD_BEEF);
    expect_both("basic_rd2", 1, 32'hDEAD_BEEF);
    sample();
    tick();
    expect_both("we0_hold", 0, 32'hDEAD_BEEF);
    expect_both("we0_hold2", 1, 32'hDEAD_BEEF);
    sample();

    // $0 is never written and never bypassed.
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    expect_both("zero_pre1", 0, 32'h0);
    expect_both("zero_pre2", 1, 32'h0);
    sample();
    tick();
    we3 = 1'b0;
    expect_both("zero_post", 0, 32'h0);
    sample();

    // Bypass behaviour with reg5=0x11, reg6=0x66 stored.
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h11;
    tick();
    wa3 = 5'd6; wd3 = 32'h66;
    tick();
    wa3 = 5'd5; wd3 = 32'h22; ra1 = 5'd5; ra2 = 5'd6;
    expect_v("byp_rd1", 0, 32'h22);
    expect_v("byp_rd2_other", 1, 32'h66);
    expect_v("nob_rd1_old", 2, 32'h11);
    expect_v("nob_rd2_other", 3, 32'h66);
    sample();
    tick();
    we3 = 1'b0;
    expect_both("byp_post", 0, 32'h22);
    sample();
    we3 = 1'b1; wd3 = 32'h33; ra2 = 5'd5;
    expect_v("byp_dual1", 0, 32'h33);
    expect_v("byp_dual2", 1, 32'h33);
    expect_v("nob_dual1", 2, 32'h22);
    expect_v("nob_dual2", 3, 32'h22);
    sample();
    tick();
    we3 = 1'b0;
    expect_both("dual_post", 1, 32'h33);
    sample();

    // Reset pulsed between edges clears contents immediately.
    we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hA5A5_A5A5;
    tick();
    we3 = 1'b0; ra1 = 5'd9; ra2 = 5'd29;
    expect_both("mid_written", 0, 32'hA5A5_A5A5);
    sample();
    tick();
    rst_n = 1'b0;
    #1;
    expect_both("mid_rst_r9", 0, 32'h0);
    expect_both("mid_rst_sp", 1, SP_V);
    sample();
    we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h0000_0077;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    expect_both("mid_wr_lost", 0, 32'h0);
    sample();
    rst_n = 1'b1;
    tick();
    expect_both("mid_after_rel", 0, 32'h0);
    sample();

    // Full sweep: reg k = k * 0x01010101.
    we3 = 1'b1;
    for (int k = 1; k < 32; k++) begin
      wa3 = 5'(k);
      wd3 = 32'(k) * 32'h0101_0101;
      tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 32; i++) perm[i] = 5'(i);
    for (int i = 31; i > 0; i--) begin
      int j;
      logic [4:0] t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 32; i++) begin
      ra1 = perm[i];
      ra2 = perm[(i + 7) % 32];
      expect_both("sweep_rd1", 0, 32'(perm[i]) * 32'h0101_0101);
      expect_both("sweep_rd2", 1, 32'(perm[(i + 7) % 32]) * 32'h0101_0101);
      sample();
    end

    for (int t = 0; t < 100; t++) begin
      if (queue_q.size() == 0) break;
      #1;
    end
    if (queue_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending %0d required 0", queue_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
